// File: rtl/mips_datapath.sv
// mips_datapath: single-cycle MIPS-subset core; clk/reset in, pc drives the instruction ROM, instruction comes back the same cycle, result is the ALU/write-back value
module mips_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] result
);
  logic [31:0] r_pc;
  logic [31:0] r_regs [32];
  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd, w_dst;
  logic [31:0] w_a, w_b, w_sext, w_zext, w_opb, w_alu, w_pc4, w_npc;
  logic        w_rtype, w_rok, w_addi, w_andi, w_ori, w_beq, w_bne, w_j;
  logic        w_sub, w_and, w_or, w_slt, w_we, w_take;
  assign w_op    = instruction[31:26];
  assign w_rs    = instruction[25:21];
  assign w_rt    = instruction[20:16];
  assign w_rd    = instruction[15:11];
  assign w_fn    = instruction[5:0];
  assign w_sext  = {{16{instruction[15]}}, instruction[15:0]};
  assign w_zext  = {16'h0000, instruction[15:0]};
  assign w_a     = w_rs == 5'd0 ? '0 : r_regs[w_rs];
  assign w_b     = w_rt == 5'd0 ? '0 : r_regs[w_rt];
  assign w_rtype = w_op == 6'h00;
  assign w_addi  = w_op == 6'h08;
  assign w_andi  = w_op == 6'h0C;
  assign w_ori   = w_op == 6'h0D;
  assign w_beq   = w_op == 6'h04;
  assign w_bne   = w_op == 6'h05;
  assign w_j     = w_op == 6'h02;
  assign w_rok   = w_rtype && (w_fn == 6'h20 || w_fn == 6'h22 || w_fn == 6'h24 || w_fn == 6'h25 || w_fn == 6'h2A);
  assign w_sub   = (w_rtype && w_fn == 6'h22) || w_beq || w_bne;
  assign w_and   = (w_rtype && w_fn == 6'h24) || w_andi;
  assign w_or    = (w_rtype && w_fn == 6'h25) || w_ori;
  assign w_slt   = w_rtype && w_fn == 6'h2A;
  assign w_opb   = (w_rtype || w_beq || w_bne) ? w_b : (w_andi || w_ori) ? w_zext : w_sext;
  assign w_alu   = w_j   ? '0 :
                   w_sub ? w_a - w_opb :
                   w_and ? w_a & w_opb :
                   w_or  ? w_a | w_opb :
                   w_slt ? {31'd0, $signed(w_a) < $signed(w_opb)} :
                           w_a + w_opb;
  assign result  = reset ? '0 : w_alu;
  assign w_we    = w_rok || w_addi || w_andi || w_ori;
  assign w_dst   = w_rtype ? w_rd : w_rt;
  assign w_pc4   = r_pc + 32'd4;
  assign w_take  = (w_beq && w_a == w_b) || (w_bne && w_a != w_b);
  assign w_npc   = w_j    ? {w_pc4[31:28], instruction[25:0], 2'b00} :
                   w_take ? w_pc4 + {w_sext[29:0], 2'b00} :
                            w_pc4;
  assign pc      = r_pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_npc;
      if (w_we && w_dst != 5'd0) r_regs[w_dst] <= w_alu;
    end
  end
endmodule

// File: tb/tb_mips_datapath.sv
// tb_mips_datapath: scoreboard bench running small programs through mips_datapath against an instruction-level model
module tb_mips_datapath;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction, pc, result;
  logic [31:0] rom [256];
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    logic [31:0] pc;
    int          idx;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];

  mips_datapath dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .pc(pc),
    .result(result)
  );

  always #5 clk = ~clk;

  assign instruction = (pc[31:10] == 22'd0) ? rom[pc[9:2]] : 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [25:0] a);
    return {6'h02, a};
  endfunction

  task automatic clear_rom;
    foreach (rom[i]) rom[i] = 32'd0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    chk("rst_result", result, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_pc", pc, 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("rst_reg%0d", i), dut.r_regs[i], 32'd0);
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    q.delete();
  endtask

  task automatic step;
    logic [31:0] ins, a, b, se, ze, res, npc;
    logic [5:0]  op, fn;
    int          d;
    bit          we;
    exp_t        e;
    #1;
    ins = (m_pc[31:10] == 22'd0) ? rom[m_pc[9:2]] : 32'd0;
    op  = ins[31:26];
    fn  = ins[5:0];
    a   = m_regs[ins[25:21]];
    b   = m_regs[ins[20:16]];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'd0, ins[15:0]};
    npc = m_pc + 32'd4;
    d   = int'(ins[20:16]);
    we  = 1'b0;
    case (op)
      6'h00: begin
        d  = int'(ins[15:11]);
        we = 1'b1;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin res = a + b; we = 1'b0; end
        endcase
      end
      6'h08: begin res = a + se; we = 1'b1; end
      6'h0C: begin res = a & ze; we = 1'b1; end
      6'h0D: begin res = a | ze; we = 1'b1; end
      6'h04: begin res = a - b; if (a == b) npc = npc + (se << 2); end
      6'h05: begin res = a - b; if (a != b) npc = npc + (se << 2); end
      6'h02: begin res = 32'd0; npc = {npc[31:28], ins[25:0], 2'b00}; end
      default: res = a + se;
    endcase
    chk("result", result, res);
    if (we && d != 0) m_regs[d] = res;
    m_pc  = npc;
    e.pc  = m_pc;
    e.idx = d;
    e.val = m_regs[d];
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("pc", pc, e.pc);
    chk($sformatf("reg%0d", e.idx), dut.r_regs[e.idx], e.val);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load_loop;
    clear_rom();
    rom[0] = i_ins(6'h08, 5'd0, 5'd8, 16'd10);
    rom[1] = r_ins(5'd0, 5'd0, 5'd9, 6'h20);
    rom[2] = r_ins(5'd9, 5'd8, 5'd9, 6'h20);
    rom[3] = i_ins(6'h08, 5'd8, 5'd8, 16'hFFFF);
    rom[4] = i_ins(6'h05, 5'd8, 5'd0, 16'hFFFD);
  endtask

  initial begin
    int n;
    clear_rom();
    rom[0] = i_ins(6'h08, 5'd0, 5'd9, 16'd45);
    do_reset();
    chk("rst_reg9_held", dut.r_regs[9], 32'd0);
    clear_rom();
    run(3);
    chk("nop_pc", pc, 32'd12);

    clear_rom();
    rom[0] = i_ins(6'h08, 5'd0, 5'd8, 16'd10);
    rom[1] = i_ins(6'h08, 5'd0, 5'd9, 16'd45);
    rom[2] = r_ins(5'd9, 5'd8, 5'd9, 6'h20);
    do_reset();
    run(2);
    chk("add_result", result, 32'd55);
    run(1);
    chk("line_reg9", dut.r_regs[9], 32'd55);
    chk("line_reg8", dut.r_regs[8], 32'd10);
    chk("line_pc", pc, 32'd12);

    load_loop();
    do_reset();
    run(32);
    chk("loop_reg9", dut.r_regs[9], 32'd55);
    chk("loop_reg8", dut.r_regs[8], 32'd0);
    chk("loop_pc", pc, 32'd20);
    run(4);
    chk("tail_pc", pc, 32'd36);
    chk("tail_reg9", dut.r_regs[9], 32'd55);

    clear_rom();
    n = 0;
    rom[n++] = i_ins(6'h08, 5'd0, 5'd8, 16'd12);
    rom[n++] = i_ins(6'h08, 5'd0, 5'd9, 16'd10);
    rom[n++] = r_ins(5'd8, 5'd9, 5'd10, 6'h22);
    rom[n++] = r_ins(5'd8, 5'd9, 5'd10, 6'h24);
    rom[n++] = r_ins(5'd8, 5'd9, 5'd10, 6'h25);
    rom[n++] = r_ins(5'd9, 5'd8, 5'd10, 6'h2A);
    rom[n++] = r_ins(5'd8, 5'd9, 5'd10, 6'h2A);
    rom[n++] = i_ins(6'h0D, 5'd0, 5'd11, 16'h4000);
    repeat (16) rom[n++] = r_ins(5'd11, 5'd11, 5'd11, 6'h20);
    rom[n++] = i_ins(6'h08, 5'd11, 5'd12, 16'hFFFF);
    rom[n++] = r_ins(5'd11, 5'd12, 5'd11, 6'h20);
    rom[n++] = i_ins(6'h08, 5'd11, 5'd11, 16'd1);
    do_reset();
    run(3);
    chk("alu_sub", dut.r_regs[10], 32'd2);
    run(1);
    chk("alu_and", dut.r_regs[10], 32'd8);
    run(1);
    chk("alu_or", dut.r_regs[10], 32'd14);
    run(1);
    chk("alu_slt_true", dut.r_regs[10], 32'd1);
    run(1);
    chk("alu_slt_false", dut.r_regs[10], 32'd0);
    run(19);
    chk("alu_max", dut.r_regs[11], 32'h7FFF_FFFF);
    run(1);
    chk("alu_wrap", dut.r_regs[11], 32'h8000_0000);

    clear_rom();
    rom[0]  = i_ins(6'h08, 5'd0, 5'd8, 16'd5);
    rom[1]  = i_ins(6'h08, 5'd0, 5'd9, 16'd5);
    rom[2]  = j_ins(26'h40);
    rom[64] = i_ins(6'h04, 5'd8, 5'd9, 16'hFFFD);
    rom[62] = i_ins(6'h08, 5'd0, 5'd0, 16'd7);
    rom[63] = j_ins(26'h50);
    do_reset();
    run(3);
    chk("j_pc", pc, 32'h0000_0100);
    run(1);
    chk("beq_back_pc", pc, 32'h0000_00F8);
    run(1);
    chk("zero_reg", dut.r_regs[0], 32'd0);
    run(1);
    chk("j2_pc", pc, 32'h0000_0140);

    load_loop();
    do_reset();
    run(10);
    do_reset();
    run(32);
    chk("rerun_reg9", dut.r_regs[9], 32'd55);
    chk("rerun_reg8", dut.r_regs[8], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_datapath.md
Name: mips_datapath

Overview:
- Single-cycle 32-bit MIPS-subset datapath: program counter, 32x32 register file, ALU, main/ALU control decode and next-PC logic.
- Drives `pc` to an external combinational instruction memory. Receives the 32-bit instruction back in the same cycle.
- Exposes the ALU/write-back result for observation.
- Register 9 ($t1) is the usual program result register and must be readable by the bench as register-file entry 9.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock; only clock in the block.
- reset  input  1  synchronous, active-high reset.
- instruction  input  32  instruction fetched at address `pc`; combinational from external memory.
- pc  output  32  current program counter (byte address, word aligned); registered.
- result  output  32  value selected for register write-back this cycle; combinational.

Behaviour:
- Reset (sampled at posedge clk while reset=1):
  - pc <= RESET_PC.
  - All 32 registers <= 0.
  - No other state exists.
  - While reset=1, result is forced to 0.
  - Reset asserted mid-program aborts at the next edge. No register write occurs on that edge.
- One instruction completes per clock:
  - Decode, register read and ALU evaluation are combinational.
  - Register write and PC update happen at the same posedge.
- Register file:
  - 2 async read ports (rs, rt), 1 sync write port.
  - Register 0 reads 0 always; writes to it are ignored.
  - Read-during-write in the same cycle returns the old value.
- Supported instructions, with opcode/funct:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A. Destination is rd.
  - addi 0x08: sign-extended imm16, destination rt.
  - andi 0x0C, ori 0x0D: zero-extended imm16, destination rt.
  - beq 0x04, bne 0x05: target = pc+4 + (signext(imm16)<<2), taken on equal / not equal. No register write.
  - j 0x02: target = {pc+4[31:28], addr26, 2'b00}. No register write.
- Arithmetic:
  - 32-bit two's complement; overflow wraps, with no trap and no flag.
  - slt is a signed compare writing 1 or 0.
- Next PC: pc+4 unless a branch is taken or j executes.
- Unknown opcode or funct: treated as a NOP (no register write, pc+4). result shows the ALU output of an add.
- result equals the ALU output for every instruction. For branches this is the rs-rt subtraction; for j it is 0.
- The instruction-memory companion must follow this contract:
  - Combinational ROM, 32-bit words, indexed by pc[31:2].
  - Locations past the loaded program return 0, which decodes to sll $0 and is a NOP via the unknown-funct rule.
  - Running off the end of the program is therefore harmless: pc keeps incrementing and registers stay unchanged.

Test Plan:
1. Reset: hold reset for 1 edge with arbitrary instruction -> pc=0, result=0, all registers 0. Deassert -> pc advances by 4 each edge on NOPs.
2. Straight-line program:
   - addi $t0,$0,10
   - addi $t1,$0,45
   - add $t1,$t1,$t0
   - Expected: after 3 edges, reg9=55, reg8=10, pc=12. result=55 during the add cycle.
3. Loop program computing sum 1..10:
   - addi $t0,$0,10
   - add $t1,$0,$0
   - loop: add $t1,$t1,$t0
   - addi $t0,$t0,-1
   - bne $t0,$0,loop
   - Expected: after 32 edges reg9=55, reg8=0. Afterwards pc increments by 4 through zero-filled memory and reg9 stays 55.
4. ALU ops with $t0=12, $t1=10:
   - sub -> 2
   - and -> 8
   - or -> 14
   - slt $t2,$t1,$t0 -> 1
   - slt $t2,$t0,$t1 -> 0
   - addi 0x7FFFFFFF+1 wraps to 0x80000000.
5. Control flow:
   - beq with equal operands jumps to the correct signed offset; test a backward offset of -3 words.
   - j 0x40 sets pc=0x100.
   - A write to $0 leaves reg0=0.
6. Reset mid-program: assert reset during the loop in scenario 3 -> next edge pc=0 and all registers 0. Program then re-runs to reg9=55.
